// File: rtl/gpio_cmd_master.sv
// Initiator for the 32-bit GPIO command bus: turns one queued request into a
// timed {opcode, enable, data} sequence and captures the response word(s).
module gpio_cmd_master #(
  parameter int NB_GPIOS      = 32,
  parameter int NB_OPCODE     = 8,
  parameter int NB_DATA       = 23,
  parameter int STROBE_CYCLES = 2,
  parameter int RESP_WAIT     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [NB_OPCODE-1:0] i_cmd_opcode,
  input  logic [NB_DATA-1:0]   i_cmd_data,
  input  logic                 i_cmd_read64,
  output logic [NB_GPIOS-1:0]  o_gpio_out,
  input  logic [NB_GPIOS-1:0]  i_gpio_in,
  output logic                 o_rsp_valid,
  output logic [63:0]          o_rsp_data,
  output logic                 o_busy
);

  // Request handshake: a request transfers on the rising clk edge where
  // i_cmd_valid and o_cmd_ready are both high; o_cmd_ready is high only in IDLE.
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, CAPTURE, DONE} state_t;

  localparam logic [7:0] S_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] W_LOAD = (RESP_WAIT > 0) ? 8'(RESP_WAIT - 1) : 8'd0;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [NB_OPCODE-1:0] op_q, op_d;
  logic [NB_DATA-1:0]   data_q, data_d;
  logic                 rd64_q, rd64_d;
  logic                 phase_q, phase_d;
  logic [63:0]          rsp_q, rsp_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [NB_GPIOS-1:0]  gpio_q, gpio_d;
  logic [NB_DATA-1:0]   addr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    rd64_d  = rd64_q;
    phase_d = phase_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          op_d    = i_cmd_opcode;
          data_d  = i_cmd_data;
          rd64_d  = i_cmd_read64;
          phase_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = S_LOAD;
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          if (RESP_WAIT == 0) begin
            state_d = CAPTURE;
          end else begin
            state_d = WAIT;
            cnt_d   = W_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      CAPTURE: begin
        if (!rd64_q) begin
          rsp_d   = {32'b0, i_gpio_in};
          state_d = DONE;
        end else if (!phase_q) begin
          // Low counter word captured; go back for the high word.
          rsp_d   = {32'b0, i_gpio_in};
          phase_d = 1'b1;
          state_d = SETUP;
        end else begin
          rsp_d[63:32] = i_gpio_in;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output word is derived from the next state so the bus changes on the edge
  // that enters each state; read64 phase selects the counter half via data[0].
  always_comb begin
    addr_d = rd64_d ? {data_d[NB_DATA-1:1], phase_d} : data_d;
    case (state_d)
      SETUP, WAIT, CAPTURE: gpio_d = {op_d, 1'b0, addr_d};
      STROBE:               gpio_d = {op_d, 1'b1, addr_d};
      default:              gpio_d = '0;
    endcase
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      op_q        <= '0;
      data_q      <= '0;
      rd64_q      <= 1'b0;
      phase_q     <= 1'b0;
      rsp_q       <= 64'd0;
      rsp_valid_q <= 1'b0;
      gpio_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rd64_q      <= rd64_d;
      phase_q     <= phase_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      gpio_q      <= gpio_d;
    end
  end

  assign o_cmd_ready = (state_q == IDLE) & ~rst;
  assign o_busy      = (state_q != IDLE);
  assign o_gpio_out  = gpio_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_q;

endmodule

// File: tb/tb_gpio_cmd_master.sv
// Bench for gpio_cmd_master: default timing (S=2, W=2) and the S=1, W=0 corner,
// per-cycle trace tables plus reset/back-to-back sequences.
module tb_gpio_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_opcode = 8'h00;
  logic [22:0] cmd_data = 23'h0;
  logic        cmd_read64 = 1'b0;
  logic [31:0] gpio_in = 32'h0;

  logic        ready_a, rsp_valid_a, busy_a;
  logic [31:0] gpio_a;
  logic [63:0] rsp_data_a;
  logic        ready_b, rsp_valid_b, busy_b;
  logic [31:0] gpio_b;
  logic [63:0] rsp_data_b;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] gpio_in;
    logic [31:0] exp_gpio;
    logic        exp_valid;
    logic        exp_busy;
    logic        chk_rsp;
    logic [63:0] exp_rsp;
  } vec_t;

  vec_t tbl[$];

  gpio_cmd_master u_dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(ready_a),
    .i_cmd_opcode(cmd_opcode), .i_cmd_data(cmd_data), .i_cmd_read64(cmd_read64),
    .o_gpio_out(gpio_a), .i_gpio_in(gpio_in),
    .o_rsp_valid(rsp_valid_a), .o_rsp_data(rsp_data_a), .o_busy(busy_a)
  );

  gpio_cmd_master #(.STROBE_CYCLES(1), .RESP_WAIT(0)) u_fast (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(ready_b),
    .i_cmd_opcode(cmd_opcode), .i_cmd_data(cmd_data), .i_cmd_read64(cmd_read64),
    .o_gpio_out(gpio_b), .i_gpio_in(gpio_in),
    .o_rsp_valid(rsp_valid_b), .o_rsp_data(rsp_data_b), .o_busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] gi, input logic [31:0] g, input logic v,
                     input logic b, input logic cr, input logic [63:0] r);
    vec_t e;
    e.gpio_in = gi; e.exp_gpio = g; e.exp_valid = v;
    e.exp_busy = b; e.chk_rsp = cr; e.exp_rsp = r;
    tbl.push_back(e);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_gpio_a",  64'(gpio_a), 64'h0);
    check("rst_valid_a", 64'(rsp_valid_a), 64'h0);
    check("rst_data_a",  rsp_data_a, 64'h0);
    check("rst_busy_a",  64'(busy_a), 64'h0);
    check("rst_ready_a", 64'(ready_a), 64'h0);
    check("rst_gpio_b",  64'(gpio_b), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready_a", 64'(ready_a), 64'h1);
    check("post_rst_busy_a",  64'(busy_a), 64'h0);
    check("post_rst_ready_b", 64'(ready_b), 64'h1);
  endtask

  // Issue one request and compare the chosen DUT against tbl, one entry per
  // cycle starting at cycle 1 after the accept edge.
  task automatic run_trace(input string tag, input bit fast, input logic [7:0] op,
                           input logic [22:0] data, input bit rd64);
    @(negedge clk);
    check({tag, "_ready"}, 64'(fast ? ready_b : ready_a), 64'h1);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_data = data; cmd_read64 = rd64;
    gpio_in = tbl[0].gpio_in;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_opcode = ~op; cmd_data = ~data; cmd_read64 = ~rd64;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      gpio_in = tbl[i].gpio_in;
      check($sformatf("%s_c%0d_gpio", tag, i + 1), 64'(fast ? gpio_b : gpio_a), 64'(tbl[i].exp_gpio));
      check($sformatf("%s_c%0d_valid", tag, i + 1), 64'(fast ? rsp_valid_b : rsp_valid_a), 64'(tbl[i].exp_valid));
      check($sformatf("%s_c%0d_busy", tag, i + 1), 64'(fast ? busy_b : busy_a), 64'(tbl[i].exp_busy));
      if (tbl[i].chk_rsp)
        check($sformatf("%s_c%0d_rsp", tag, i + 1), fast ? rsp_data_b : rsp_data_a, tbl[i].exp_rsp);
    end
    tbl.delete();
  endtask

  initial begin
    int lat, n_pulse, p1, p2;
    #12;
    do_reset();

    // Single request, S=2 W=2
    for (int c = 1; c <= 8; c++) begin
      logic [31:0] g;
      g = (c == 2 || c == 3) ? 32'h0380_0001 : (c <= 6) ? 32'h0300_0001 : 32'h0;
      add(32'hDEAD_BEEF, g, c == 7, c <= 7, c >= 7, 64'h0000_0000_DEAD_BEEF);
    end
    run_trace("single", 1'b0, 8'h03, 23'h000001, 1'b0);

    // read64: request data bit 0 set, must be forced 0 then 1
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      logic [31:0] g, gi;
      gi = (c <= 6) ? 32'h1111_2222 : 32'h3333_4444;
      if (c == 2 || c == 3)      g = 32'h1080_0004;
      else if (c <= 6)           g = 32'h1000_0004;
      else if (c == 8 || c == 9) g = 32'h1080_0005;
      else if (c <= 12)          g = 32'h1000_0005;
      else                       g = 32'h0;
      add(gi, g, c == 13, c <= 13, c >= 13, 64'h3333_4444_1111_2222);
    end
    run_trace("rd64", 1'b0, 8'h10, 23'h000005, 1'b1);

    // Corner timing S=1 W=0
    do_reset();
    add(32'hDEAD_BEEF, 32'h0300_0001, 1'b0, 1'b1, 1'b0, 64'h0);
    add(32'hDEAD_BEEF, 32'h0380_0001, 1'b0, 1'b1, 1'b0, 64'h0);
    add(32'hDEAD_BEEF, 32'h0300_0001, 1'b0, 1'b1, 1'b0, 64'h0);
    add(32'hDEAD_BEEF, 32'h0,         1'b1, 1'b1, 1'b1, 64'h0000_0000_DEAD_BEEF);
    add(32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF);
    run_trace("fast", 1'b1, 8'h03, 23'h000001, 1'b0);

    // Back-to-back with valid held high
    do_reset();
    gpio_in = 32'hDEAD_BEEF;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 8'h03; cmd_data = 23'h000001; cmd_read64 = 1'b0;
    @(posedge clk); #1;
    n_pulse = 0; p1 = -1; p2 = -1;
    for (int c = 1; c <= 22; c++) begin
      if (c == 8) check("b2b_ready_c8", 64'(ready_a), 64'h1);
      if (c == 9) begin
        check("b2b_gpio_c9", 64'(gpio_a), 64'h0300_0001);
        check("b2b_busy_c9", 64'(busy_a), 64'h1);
        cmd_valid = 1'b0;
      end
      if (rsp_valid_a) begin
        n_pulse++;
        if (p1 < 0) p1 = c; else if (p2 < 0) p2 = c;
      end
      @(posedge clk); #1;
    end
    check("b2b_pulses", 64'(n_pulse), 64'd2);
    check("b2b_first", 64'(p1), 64'd7);
    check("b2b_second", 64'(p2), 64'd15);

    // Reset in the middle of a read64 strobe
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 8'h10; cmd_data = 23'h000005; cmd_read64 = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_strobe_gpio", 64'(gpio_a), 64'h1080_0004);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_gpio",  64'(gpio_a), 64'h0);
    check("mid_rst_busy",  64'(busy_a), 64'h0);
    check("mid_rst_valid", 64'(rsp_valid_a), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_pulse = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (rsp_valid_a) n_pulse++;
    end
    check("mid_rst_no_rsp", 64'(n_pulse), 64'd0);
    gpio_in = 32'hCAFE_F00D;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 8'h03; cmd_data = 23'h000001; cmd_read64 = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (rsp_valid_a) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    check("after_rst_latency", 64'(lat), 64'd7);
    check("after_rst_rsp", rsp_data_a, 64'h0000_0000_CAFE_F00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
